// File: rtl/player_pkg.sv
// Shared direction/sprite/sword codes, FSM state type and grid-position helpers
// for the player movement and attack logic.
package player_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ATTACK = 2'd2
    } state_t;

    localparam logic [3:0] SWORD_ON     = 4'b0001;
    localparam logic [3:0] SWORD_OFF    = 4'b1111;
    localparam logic [3:0] SPR_A        = 4'b0011;
    localparam logic [3:0] SPR_B        = 4'b0010;
    localparam logic [1:0] ORIENT_RIGHT = 2'b01;
    localparam logic [1:0] ORIENT_LEFT  = 2'b11;

    // Each axis is widened to STEP_W bits so a step off either grid edge
    // lands on a value outside the legal range; COORD_W must stay below STEP_W.
    localparam int STEP_W = 8;
    typedef logic [STEP_W-1:0] coord_t;

    function automatic logic [2*STEP_W-1:0] step_pos(input logic [2*STEP_W-1:0] pos,
                                                     input dir_t dir);
        coord_t x;
        coord_t y;
        x = pos[2*STEP_W-1:STEP_W];
        y = pos[STEP_W-1:0];
        case (dir)
            DIR_UP:    y = y - coord_t'(1);
            DIR_RIGHT: x = x + coord_t'(1);
            DIR_DOWN:  y = y + coord_t'(1);
            DIR_LEFT:  x = x - coord_t'(1);
            default:   ;
        endcase
        return {x, y};
    endfunction

    // Unsigned wrap trick: v lies in [lo, hi] exactly when v - lo <= hi - lo.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v - lo) <= (hi - lo);
    endfunction

    function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/player_input_latch.sv
// Held-button mask built from press/release events, a `fresh` flag for new
// presses, and the right > left > down > up direction select.
module player_input_latch
    import player_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] input_data,
    input  logic       respawn,
    input  logic       consume_fresh,
    output logic       attack_held,
    output logic       fresh,
    output logic       dir_valid,
    output dir_t       dir_sel
);

    logic [4:0] held;
    logic [4:0] pressed;
    logic [4:0] released;

    assign pressed  = input_data[9:5];
    assign released = input_data[4:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held  <= '0;
            fresh <= 1'b0;
        end else if (respawn) begin
            held  <= '0;
            fresh <= 1'b0;
        end else begin
            // A press replaces the mask outright, so it wins over a same-cycle release.
            if (pressed != '0)
                held <= pressed;
            else if (released != '0)
                held <= held & ~released;
            if (pressed[3:0] != '0)
                fresh <= 1'b1;
            else if (consume_fresh)
                fresh <= 1'b0;
        end
    end

    assign attack_held = held[4];
    assign dir_valid   = |held[3:0];

    always_comb begin
        dir_sel = DIR_UP;
        if (held[3])
            dir_sel = DIR_RIGHT;
        else if (held[2])
            dir_sel = DIR_LEFT;
        else if (held[1])
            dir_sel = DIR_DOWN;
    end

endmodule

// File: rtl/player_logic_grid.sv
// Grid player controller: frame-strobed movement with hold-to-repeat, wall
// blocking, timed sword attack with cooldown, sprite animation and respawn.
module player_logic_grid
    import player_pkg::*;
#(
    parameter int COORD_W        = 4,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 15,
    parameter int Y_MIN          = 1,
    parameter int Y_MAX          = 11,
    parameter int ATTACK_TICKS   = 4,
    parameter int COOLDOWN_TICKS = 2,
    parameter int REPEAT_DELAY   = 6,
    parameter int REPEAT_RATE    = 3,
    parameter int ANIM_PERIOD    = 21,
    parameter int ANIM_SPLIT     = 7,
    parameter logic [2*COORD_W-1:0] SPAWN_POS = {4'd1, 4'd3}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [9:0]           input_data,
    input  logic                 respawn,
    input  logic [2*COORD_W-1:0] respawn_pos,
    output logic [2*COORD_W-1:0] target_pos,
    input  logic                 target_blocked,
    output logic [2*COORD_W-1:0] player_pos,
    output logic [1:0]           player_orientation,
    output logic [1:0]           player_direction,
    output logic [3:0]           player_sprite,
    output logic [2*COORD_W-1:0] sword_position,
    output logic [3:0]           sword_visible,
    output logic [1:0]           sword_orientation,
    output logic                 busy
);

    localparam int PW     = 2 * COORD_W;
    localparam int RPT_W  = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam int CD_W   = $clog2(COOLDOWN_TICKS + 1);
    localparam int ATK_W  = $clog2(ATTACK_TICKS + 1);
    localparam int ANIM_W = $clog2(ANIM_PERIOD);
    localparam coord_t XMIN_C = coord_t'(X_MIN);
    localparam coord_t XMAX_C = coord_t'(X_MAX);
    localparam coord_t YMIN_C = coord_t'(Y_MIN);
    localparam coord_t YMAX_C = coord_t'(Y_MAX);

    state_t               state;
    dir_t                 move_dir;
    dir_t                 step_dir;
    dir_t                 dir_sel;
    logic [RPT_W-1:0]     rpt_cnt;
    logic [CD_W-1:0]      cd_cnt;
    logic [ATK_W-1:0]     atk_cnt;
    logic [ANIM_W-1:0]    anim_cnt;
    logic                 attack_held;
    logic                 fresh;
    logic                 dir_valid;
    logic                 attack_go;
    logic                 consume_fresh;
    logic                 in_bounds;
    logic [2*STEP_W-1:0]  wide_target;
    coord_t               tx;
    coord_t               ty;
    logic [COORD_W-1:0]   resp_x;
    logic [COORD_W-1:0]   resp_y;

    player_input_latch u_input_latch (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .respawn       (respawn),
        .consume_fresh (consume_fresh),
        .attack_held   (attack_held),
        .fresh         (fresh),
        .dir_valid     (dir_valid),
        .dir_sel       (dir_sel)
    );

    // The tile looked at this cycle: the held direction while idle, the latched
    // move direction in MOVE, and the sword facing during ATTACK.
    always_comb begin
        step_dir = dir_t'(player_direction);
        case (state)
            IDLE:    if (dir_valid) step_dir = dir_sel;
            MOVE:    step_dir = move_dir;
            ATTACK:  step_dir = dir_t'(sword_orientation);
            default: ;
        endcase
    end

    assign wide_target = step_pos({coord_t'(player_pos[PW-1:COORD_W]),
                                   coord_t'(player_pos[COORD_W-1:0])}, step_dir);
    assign tx          = wide_target[2*STEP_W-1:STEP_W];
    assign ty          = wide_target[STEP_W-1:0];
    assign in_bounds   = in_range(tx, XMIN_C, XMAX_C) && in_range(ty, YMIN_C, YMAX_C);
    assign target_pos  = {COORD_W'(tx), COORD_W'(ty)};

    assign resp_x = COORD_W'(clamp(coord_t'(respawn_pos[PW-1:COORD_W]), XMIN_C, XMAX_C));
    assign resp_y = COORD_W'(clamp(coord_t'(respawn_pos[COORD_W-1:0]), YMIN_C, YMAX_C));

    assign attack_go     = (state == IDLE) && attack_held && (cd_cnt == '0);
    assign consume_fresh = trigger && (state == IDLE) && !attack_go && dir_valid && fresh;
    assign busy          = (state != IDLE) || (cd_cnt != '0);
    assign player_sprite = (anim_cnt >= ANIM_W'(ANIM_SPLIT)) ? SPR_B : SPR_A;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            anim_cnt <= '0;
        else if (trigger)
            anim_cnt <= (anim_cnt == ANIM_W'(ANIM_PERIOD - 1)) ? '0 : anim_cnt + ANIM_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            move_dir           <= DIR_RIGHT;
            rpt_cnt            <= '0;
            cd_cnt             <= '0;
            atk_cnt            <= '0;
            player_pos         <= SPAWN_POS;
            player_orientation <= ORIENT_RIGHT;
            player_direction   <= DIR_RIGHT;
            sword_position     <= '0;
            sword_visible      <= SWORD_OFF;
            sword_orientation  <= DIR_RIGHT;
        end else if (respawn) begin
            state            <= IDLE;
            rpt_cnt          <= '0;
            cd_cnt           <= '0;
            atk_cnt          <= '0;
            player_pos       <= {resp_x, resp_y};
            player_direction <= DIR_RIGHT;
            sword_visible    <= SWORD_OFF;
        end else if (trigger) begin
            case (state)
                IDLE: begin
                    if (cd_cnt != '0)
                        cd_cnt <= cd_cnt - CD_W'(1);
                    if (attack_go) begin
                        state             <= ATTACK;
                        atk_cnt           <= '0;
                        player_direction  <= step_dir;
                        sword_orientation <= step_dir;
                    end else if (dir_valid && fresh) begin
                        state    <= MOVE;
                        move_dir <= dir_sel;
                        rpt_cnt  <= RPT_W'(REPEAT_DELAY);
                    end else if (dir_valid && rpt_cnt <= RPT_W'(1)) begin
                        // Counter reaches zero on this trigger: auto-repeat fires now.
                        state    <= MOVE;
                        move_dir <= dir_sel;
                        rpt_cnt  <= RPT_W'(REPEAT_RATE);
                    end else if (dir_valid) begin
                        rpt_cnt <= rpt_cnt - RPT_W'(1);
                    end
                end
                MOVE: begin
                    player_direction <= move_dir;
                    if (in_bounds && !target_blocked) begin
                        player_pos <= target_pos;
                        if (move_dir == DIR_RIGHT)
                            player_orientation <= ORIENT_RIGHT;
                        else if (move_dir == DIR_LEFT)
                            player_orientation <= ORIENT_LEFT;
                    end
                    state <= IDLE;
                end
                ATTACK: begin
                    // Walls never hide the sword; only leaving the grid does.
                    if (atk_cnt == '0) begin
                        sword_position <= target_pos;
                        sword_visible  <= in_bounds ? SWORD_ON : SWORD_OFF;
                    end
                    if (atk_cnt == ATK_W'(ATTACK_TICKS - 1)) begin
                        sword_visible <= SWORD_OFF;
                        cd_cnt        <= CD_W'(COOLDOWN_TICKS);
                        state         <= IDLE;
                    end else begin
                        atk_cnt <= atk_cnt + ATK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
